// File: rtl/schmidl_cox_metric_pkg.sv
// Shared widths and sc16 sample/correlation payload types for the Schmidl-Cox metric.
package schmidl_cox_metric_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DATA_W   = 2 * SAMPLE_W;
  localparam int unsigned PROD_W   = 33;
  localparam int unsigned CORR_W   = 2 * PROD_W;
  localparam int unsigned PSAT_W   = 32;
  localparam int unsigned METRIC_W = 64;

  // sc16 sample as carried on the stream: {I[31:16], Q[15:0]}
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] i;
    logic signed [SAMPLE_W-1:0] q;
  } sc16_t;

  // Exact complex product x * conj(xd)
  typedef struct packed {
    logic signed [PROD_W-1:0] i;
    logic signed [PROD_W-1:0] q;
  } corr_t;

endpackage

// File: rtl/sample_delay_line.sv
// Circular delay line: returns the sample pushed DEPTH pushes ago, zero until DEPTH pushes seen.
module sample_delay_line #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fill;
  logic             full_c;

  assign full_c = (fill == CNT_W'(DEPTH));
  // Read the slot about to be overwritten: it holds the sample from DEPTH pushes back.
  assign dout_c = full_c ? mem[wr_ptr] : '0;

  // Write pointer and saturating fill counter
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (!full_c) fill <= fill + CNT_W'(1);
    end
  end

  // Sample storage; contents before fill completes are masked, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/schmidl_cox_metric.sv
// Schmidl-Cox timing metric M(n) = |sum_W x(n-m) conj(x(n-m-L))|^2, 4-stage 1:1 stream.
module schmidl_cox_metric
  import schmidl_cox_metric_pkg::*;
#(
  parameter int unsigned DELAY_LEN  = 64,
  parameter int unsigned WINDOW_LEN = 64,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [DATA_W-1:0]   i_tdata,
  input  logic                i_tlast,
  input  logic                i_tvalid,
  output logic                i_tready,
  output logic [METRIC_W-1:0] o_tdata,
  output logic                o_tlast,
  output logic                o_tvalid,
  input  logic                o_tready
);

  localparam int unsigned ACC_W = PROD_W + $clog2(WINDOW_LEN) + 1;
  localparam logic signed [ACC_W-1:0]  P_MAX = ACC_W'($signed(32'h7fff_ffff));
  localparam logic signed [ACC_W-1:0]  P_MIN = ACC_W'($signed(32'h8000_0000));

  logic flush_c, en_c, acc_in_c;

  assign flush_c  = !reset_n || clear;
  assign en_c     = !o_tvalid || o_tready;
  assign i_tready = en_c;
  assign acc_in_c = i_tvalid && en_c;

  // ---------------- S0: lag-L delay line ----------------
  logic [DATA_W-1:0] xd_c;
  sc16_t             s0_x, s0_xd;
  logic              s0_valid, s0_last;

  sample_delay_line #(.WIDTH(DATA_W), .DEPTH(DELAY_LEN)) u_line_a (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .push   (acc_in_c),
    .din    (i_tdata),
    .dout_c (xd_c)
  );

  // Capture current and lagged sample
  always_ff @(posedge clk) begin
    if (flush_c) begin
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      s0_x     <= '0;
      s0_xd    <= '0;
    end else if (en_c) begin
      s0_valid <= acc_in_c;
      if (acc_in_c) begin
        s0_x    <= i_tdata;
        s0_xd   <= xd_c;
        s0_last <= i_tlast;
      end
    end
  end

  // ---------------- S1: complex product and window delay line ----------------
  logic signed [2*SAMPLE_W-1:0] p_ii_c, p_qq_c, p_qi_c, p_iq_c;
  logic signed [PROD_W-1:0]     ci_c, cq_c;
  corr_t                        c_c, cd_c;
  corr_t                        s1_c, s1_cd;
  logic                         s1_valid, s1_last, push_b_c;

  // x * conj(xd), exact in 33 bits
  always_comb begin
    p_ii_c = 32'($signed(s0_x.i)) * 32'($signed(s0_xd.i));
    p_qq_c = 32'($signed(s0_x.q)) * 32'($signed(s0_xd.q));
    p_qi_c = 32'($signed(s0_x.q)) * 32'($signed(s0_xd.i));
    p_iq_c = 32'($signed(s0_x.i)) * 32'($signed(s0_xd.q));
    ci_c   = PROD_W'(p_ii_c) + PROD_W'(p_qq_c);
    cq_c   = PROD_W'(p_qi_c) - PROD_W'(p_iq_c);
    c_c    = {ci_c, cq_c};
  end

  assign push_b_c = en_c && s0_valid;

  sample_delay_line #(.WIDTH(CORR_W), .DEPTH(WINDOW_LEN)) u_line_b (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .push   (push_b_c),
    .din    (c_c),
    .dout_c (cd_c)
  );

  // Register product entering and leaving the window
  always_ff @(posedge clk) begin
    if (flush_c) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_c     <= '0;
      s1_cd    <= '0;
    end else if (en_c) begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_c    <= c_c;
        s1_cd   <= cd_c;
        s1_last <= s0_last;
      end
    end
  end

  // ---------------- S2: running window sum ----------------
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic                    s2_valid, s2_last;

  // Sliding-window accumulate: add newest, drop oldest
  always_ff @(posedge clk) begin
    if (flush_c) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      acc_i    <= '0;
      acc_q    <= '0;
    end else if (en_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        acc_i   <= acc_i + ACC_W'($signed(s1_c.i)) - ACC_W'($signed(s1_cd.i));
        acc_q   <= acc_q + ACC_W'($signed(s1_c.q)) - ACC_W'($signed(s1_cd.q));
        s2_last <= s1_last;
      end
    end
  end

  // ---------------- S3: scale, saturate, square ----------------
  function automatic logic signed [PSAT_W-1:0] sat_p(input logic signed [ACC_W-1:0] v);
    if (v > P_MAX)      sat_p = $signed(32'h7fff_ffff);
    else if (v < P_MIN) sat_p = $signed(32'h8000_0000);
    else                sat_p = PSAT_W'(v);
  endfunction

  logic signed [ACC_W-1:0]    sh_i_c, sh_q_c;
  logic signed [PSAT_W-1:0]   p_i_c, p_q_c;
  logic signed [2*PSAT_W-1:0] sq_i_c, sq_q_c;
  logic [METRIC_W-1:0]        m_c;

  // |p|^2 of the scaled, saturated window sum
  always_comb begin
    sh_i_c = acc_i >>> SHIFT;
    sh_q_c = acc_q >>> SHIFT;
    p_i_c  = sat_p(sh_i_c);
    p_q_c  = sat_p(sh_q_c);
    sq_i_c = 64'(p_i_c) * 64'(p_i_c);
    sq_q_c = 64'(p_q_c) * 64'(p_q_c);
    m_c    = METRIC_W'(sq_i_c) + METRIC_W'(sq_q_c);
  end

  // Output register, held while stalled
  always_ff @(posedge clk) begin
    if (flush_c) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
    end else if (en_c) begin
      o_tvalid <= s2_valid;
      if (s2_valid) begin
        o_tdata <= m_c;
        o_tlast <= s2_last;
      end
    end
  end

endmodule

// File: tb/tb_schmidl_cox_metric.sv
// Directed bench for schmidl_cox_metric (L=W=64); a SHIFT=8 instance shares the same stimulus.
module tb_schmidl_cox_metric;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        o_tready = 1'b0;
  logic        i_tready, o_tlast, o_tvalid;
  logic [63:0] o_tdata;
  logic        i_tready8, o_tlast8, o_tvalid8;
  logic [63:0] o_tdata8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] got_m  [512];
  logic [63:0] got_m8 [512];
  logic        got_l  [512];
  int          outs, ins, first_acc, first_vld;
  bit          timed_out;

  localparam logic [31:0] RAMP_X = {16'd1000, 16'd0};
  localparam logic [31:0] MAX_X  = {16'd32767, 16'd32767};

  always #5 clk = ~clk;

  schmidl_cox_metric #(.DELAY_LEN(64), .WINDOW_LEN(64), .SHIFT(0)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  schmidl_cox_metric #(.DELAY_LEN(64), .WINDOW_LEN(64), .SHIFT(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready8),
    .o_tdata(o_tdata8), .o_tlast(o_tlast8), .o_tvalid(o_tvalid8), .o_tready(o_tready)
  );

  // Expected metric for constant x=(1000,0): zero, linear P ramp, then steady 64e6
  function automatic logic [63:0] ramp_m(input int n);
    logic [63:0] v;
    if (n < 64)       v = 64'd0;
    else if (n < 128) v = 64'(n - 63) * 64'd1000000;
    else              v = 64'd64 * 64'd1000000;
    return v * v;
  endfunction

  task automatic pulse_reset(input bit use_clear);
    @(negedge clk);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;
    if (use_clear) clear = 1'b1; else reset_n = 1'b0;
    @(negedge clk);
    clear   = 1'b0;
    reset_n = 1'b1;
  endtask

  // Drive n_in samples and collect up to n_out outputs, with random valid/ready throttling
  task automatic run_stream(input int n_in, input int n_out, input int valid_pct,
                            input int ready_pct, input logic [31:0] data,
                            input int last_period, input int budget);
    int cyc;
    cyc = 0; outs = 0; ins = 0; first_acc = -1; first_vld = -1;
    while (outs < n_out && cyc < budget) begin
      @(negedge clk);
      o_tready = ($urandom_range(99) < ready_pct);
      if (ins < n_in) begin
        i_tvalid = ($urandom_range(99) < valid_pct);
        i_tdata  = data;
        i_tlast  = (last_period != 0) && ((ins % last_period) == last_period - 1);
      end else begin
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
      end
      #1;
      if (o_tvalid && first_vld < 0) first_vld = cyc;
      if (i_tvalid && i_tready) begin
        if (first_acc < 0) first_acc = cyc;
        ins++;
      end
      if (o_tvalid && o_tready) begin
        got_m[outs]  = o_tdata;
        got_l[outs]  = o_tlast;
        got_m8[outs] = o_tvalid8 ? o_tdata8 : 64'hdead_beef_dead_beef;
        outs++;
      end
      cyc++;
    end
    timed_out = (outs < n_out);
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    o_tready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", o_tvalid); end
    n_checks++;
    if (o_tdata !== 64'd0) begin n_fail++; $display("FAIL reset_tdata: got %0d expected 0", o_tdata); end
    n_checks++;
    if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", o_tlast); end
    n_checks++;
    if (i_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b expected 1", i_tready); end
    reset_n = 1'b1;
  endtask

  task automatic test_ramp;
    pulse_reset(1'b0);
    run_stream(200, 200, 100, 100, RAMP_X, 0, 2000);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL ramp_timeout: got %0d outputs expected 200", outs); end
    for (int i = 0; i < outs; i++) begin
      n_checks++;
      if (got_m[i] !== ramp_m(i)) begin
        n_fail++; $display("FAIL ramp[%0d]: got %0d expected %0d", i, got_m[i], ramp_m(i));
      end
    end
  endtask

  task automatic test_zero;
    int extra;
    pulse_reset(1'b0);
    run_stream(500, 500, 100, 100, 32'd0, 0, 2000);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL zero_timeout: got %0d outputs expected 500", outs); end
    n_checks++;
    if (first_vld - first_acc !== 4) begin
      n_fail++; $display("FAIL zero_latency: got %0d expected 4", first_vld - first_acc);
    end
    for (int i = 0; i < outs; i++) begin
      n_checks++;
      if (got_m[i] !== 64'd0) begin n_fail++; $display("FAIL zero[%0d]: got %0d expected 0", i, got_m[i]); end
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      #1;
      if (o_tvalid) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL zero_extra_outputs: got %0d expected 0", extra); end
  endtask

  task automatic test_backpressure;
    pulse_reset(1'b0);
    run_stream(200, 200, 70, 50, RAMP_X, 0, 5000);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL bp_timeout: got %0d outputs expected 200", outs); end
    for (int i = 0; i < outs; i++) begin
      n_checks++;
      if (got_m[i] !== ramp_m(i)) begin
        n_fail++; $display("FAIL bp[%0d]: got %0d expected %0d", i, got_m[i], ramp_m(i));
      end
    end
  endtask

  task automatic test_saturation;
    logic [63:0] p1, psat, e_first, e_first8, e_sat, e_sat8;
    p1       = 64'd2 * 64'd32767 * 64'd32767;
    psat     = 64'd2147483647;
    e_first  = p1 * p1;
    e_first8 = (p1 >> 8) * (p1 >> 8);
    e_sat    = psat * psat;
    e_sat8   = ((64'd64 * p1) >> 8) * ((64'd64 * p1) >> 8);
    pulse_reset(1'b0);
    run_stream(200, 200, 100, 100, MAX_X, 0, 2000);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL sat_timeout: got %0d outputs expected 200", outs); end
    n_checks++;
    if (got_m[63] !== 64'd0) begin n_fail++; $display("FAIL sat_warmup: got %0d expected 0", got_m[63]); end
    n_checks++;
    if (got_m[64] !== e_first) begin n_fail++; $display("FAIL sat_first: got %0d expected %0d", got_m[64], e_first); end
    n_checks++;
    if (got_m8[64] !== e_first8) begin n_fail++; $display("FAIL sat_first_shift8: got %0d expected %0d", got_m8[64], e_first8); end
    n_checks++;
    if (got_m[65] !== e_sat) begin n_fail++; $display("FAIL sat_clip: got %0d expected %0d", got_m[65], e_sat); end
    n_checks++;
    if (got_m[199] !== e_sat) begin n_fail++; $display("FAIL sat_steady: got %0d expected %0d", got_m[199], e_sat); end
    n_checks++;
    if (got_m8[199] !== e_sat8) begin n_fail++; $display("FAIL sat_steady_shift8: got %0d expected %0d", got_m8[199], e_sat8); end
  endtask

  task automatic test_clear;
    for (int k = 0; k < 2; k++) begin
      pulse_reset(1'b0);
      run_stream(100, 97, 100, 100, RAMP_X, 0, 1000);
      @(negedge clk);
      i_tvalid = 1'b1;
      i_tdata  = RAMP_X;
      o_tready = 1'b1;
      if (k == 1) clear = 1'b1; else reset_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL flush%0d_tvalid: got %b expected 0", k, o_tvalid); end
      n_checks++;
      if (o_tdata !== 64'd0) begin n_fail++; $display("FAIL flush%0d_tdata: got %0d expected 0", k, o_tdata); end
      clear    = 1'b0;
      reset_n  = 1'b1;
      i_tvalid = 1'b0;
      run_stream(200, 200, 100, 100, RAMP_X, 0, 2000);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL flush%0d_timeout: got %0d outputs expected 200", k, outs); end
      for (int i = 0; i < outs; i++) begin
        n_checks++;
        if (got_m[i] !== ramp_m(i)) begin
          n_fail++; $display("FAIL flush%0d_ramp[%0d]: got %0d expected %0d", k, i, got_m[i], ramp_m(i));
        end
      end
    end
  endtask

  task automatic test_tlast;
    pulse_reset(1'b0);
    run_stream(200, 200, 100, 100, RAMP_X, 80, 2000);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL tlast_timeout: got %0d outputs expected 200", outs); end
    for (int i = 0; i < outs; i++) begin
      n_checks++;
      if (got_l[i] !== ((i % 80) == 79)) begin
        n_fail++; $display("FAIL tlast[%0d]: got %b expected %b", i, got_l[i], ((i % 80) == 79));
      end
      n_checks++;
      if (got_m[i] !== ramp_m(i)) begin
        n_fail++; $display("FAIL tlast_metric[%0d]: got %0d expected %0d", i, got_m[i], ramp_m(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_zero();
    test_backpressure();
    test_saturation();
    test_clear();
    test_tlast();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
